// File: rtl/capture_buffer_if.sv
// Readout handshake bundle between the capture buffer and the host-readout stage.
//   rdValid - producer has a sample on rdData
//   rdReady - consumer accepts rdData this cycle
//   rdData  - readout sample, DATA_WIDTH bits
//   rdLast  - marks the final sample of a capture
// master: the capture buffer (drives valid/data/last). slave: the host-readout stage.
interface capture_buffer_if #(
    parameter int DATA_WIDTH = 3
);
    logic                  rdValid;
    logic                  rdReady;
    logic [DATA_WIDTH-1:0] rdData;
    logic                  rdLast;

    modport master (output rdValid, output rdData, output rdLast, input rdReady);
    modport slave  (input rdValid, input rdData, input rdLast, output rdReady);
endinterface

// File: rtl/capture_buffer.sv
// Capture buffer sitting directly behind the trigger stage.
// Keeps a circular pre-trigger history, records a fixed post-trigger window so that
// every capture is exactly DEPTH samples, then streams it oldest-first over the
// rd handshake. Pulses trigClear when an arm is accepted to clear the sticky trigger.
// Ports:
//   clk_PLL      - sampling clock (shared with the trigger stage)
//   reset        - synchronous, active-low
//   arm          - start-capture request, honoured only while idle
//   dataIn       - sample from the trigger stage
//   triggerIn    - sticky trigger flag from the trigger stage
//   preTrigDepth - pre-trigger sample count, latched at arm
//   trigClear    - one-cycle pulse resetting the trigger stage
//   busy         - capture or readout in progress
//   done         - capture complete; held until the next accepted arm
//   rd           - readout handshake (rdValid/rdReady/rdData/rdLast)
module capture_buffer #(
    parameter int DATA_WIDTH = 3,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk_PLL,
    input  logic                  reset,
    input  logic                  arm,
    input  logic [DATA_WIDTH-1:0] dataIn,
    input  logic                  triggerIn,
    input  logic [ADDR_WIDTH-1:0] preTrigDepth,
    output logic                  trigClear,
    output logic                  busy,
    output logic                  done,
    capture_buffer_if.master      rd
);
    localparam int DEPTH = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]   DEPTH_C  = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

    typedef enum logic [2:0] {IDLE, FILL, ARMED, POST, READOUT} state_t;
    state_t state, stateNext;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wrPtr;
    logic [ADDR_WIDTH-1:0] rdAddr;
    logic [ADDR_WIDTH-1:0] preLat;
    logic [ADDR_WIDTH:0]   wrCnt;
    logic [ADDR_WIDTH:0]   rdCnt;
    logic [ADDR_WIDTH:0]   postLen;
    logic                  writeEn;
    logic                  loadEn;
    logic                  xferLast;

    logic                  vld_p1;
    logic [DATA_WIDTH-1:0] rdData_p1;
    logic                  rdLast_p1;

    // preTrigDepth is ADDR_WIDTH bits wide, so it can never exceed DEPTH-1 and
    // latching it directly already gives min(preTrigDepth, DEPTH-1).
    assign postLen  = DEPTH_C - {1'b0, preLat};
    assign writeEn  = (state == FILL) || (state == ARMED) || (state == POST);
    // The output register doubles as the memory read register: reload whenever it
    // is empty or being drained, which sustains one sample per cycle.
    assign loadEn   = (state == READOUT) && (!vld_p1 || rd.rdReady);
    assign xferLast = vld_p1 && rd.rdReady && rdLast_p1;
    assign busy     = (state != IDLE);

    assign rd.rdValid = vld_p1;
    assign rd.rdData  = rdData_p1;
    assign rd.rdLast  = rdLast_p1;

    always_ff @(posedge clk_PLL) begin
        if (!reset) state <= IDLE;
        else        state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE:    if (arm) stateNext = (preTrigDepth == '0) ? ARMED : FILL;
            FILL:    if (wrCnt + CNT_ONE == {1'b0, preLat}) stateNext = ARMED;
            ARMED:   if (triggerIn) stateNext = (postLen == CNT_ONE) ? READOUT : POST;
            POST:    if (wrCnt + CNT_ONE == postLen) stateNext = READOUT;
            READOUT: if (xferLast) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Sample memory: no reset, contents are meaningless until written.
    always_ff @(posedge clk_PLL) begin
        if (writeEn) mem[wrPtr] <= dataIn;
    end

    always_ff @(posedge clk_PLL) begin
        if (!reset) begin
            wrPtr     <= '0;
            rdAddr    <= '0;
            preLat    <= '0;
            wrCnt     <= '0;
            rdCnt     <= '0;
            trigClear <= 1'b0;
            done      <= 1'b0;
            vld_p1    <= 1'b0;
            rdLast_p1 <= 1'b0;
            rdData_p1 <= '0;
        end else begin
            trigClear <= 1'b0;
            if (writeEn) wrPtr <= wrPtr + ADDR_ONE;
            if ((state != READOUT) && (stateNext == READOUT)) done <= 1'b1;
            case (state)
                IDLE: begin
                    if (arm) begin
                        preLat    <= preTrigDepth;
                        wrPtr     <= '0;
                        wrCnt     <= '0;
                        rdCnt     <= '0;
                        trigClear <= 1'b1;
                        done      <= 1'b0;
                    end
                end
                FILL: wrCnt <= wrCnt + CNT_ONE;
                ARMED: begin
                    // The trigger sample lands at wrPtr; the capture starts pre
                    // samples earlier in the ring.
                    if (triggerIn) begin
                        rdAddr <= wrPtr - preLat;
                        wrCnt  <= CNT_ONE;
                    end
                end
                POST: wrCnt <= wrCnt + CNT_ONE;
                // Read stage: memory -> output register (_p1)
                READOUT: begin
                    if (loadEn) begin
                        if (rdCnt != DEPTH_C) begin
                            rdData_p1 <= mem[rdAddr];
                            vld_p1    <= 1'b1;
                            rdLast_p1 <= (rdCnt == DEPTH_C - CNT_ONE);
                            rdAddr    <= rdAddr + ADDR_ONE;
                            rdCnt     <= rdCnt + CNT_ONE;
                        end else begin
                            vld_p1    <= 1'b0;
                            rdLast_p1 <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_capture_buffer.sv
module tb_capture_buffer;
    localparam int DW    = 3;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk_PLL = 1'b0;
    logic          reset = 1'b0;
    logic          arm = 1'b0;
    logic          triggerIn = 1'b0;
    logic [DW-1:0] dataIn = '0;
    logic [AW-1:0] preTrigDepth = '0;
    logic          trigClear;
    logic          busy;
    logic          done;

    capture_buffer_if #(.DATA_WIDTH(DW)) rdIf();

    capture_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk_PLL      (clk_PLL),
        .reset        (reset),
        .arm          (arm),
        .dataIn       (dataIn),
        .triggerIn    (triggerIn),
        .preTrigDepth (preTrigDepth),
        .trigClear    (trigClear),
        .busy         (busy),
        .done         (done),
        .rd           (rdIf)
    );

    always #5 clk_PLL = ~clk_PLL;

    int nCmp = 0;
    int nErr = 0;
    int expCap [DEPTH];
    int rxBuf  [DEPTH];
    int refRx  [DEPTH];
    int d      [128];
    bit expActive = 1'b0;
    bit readyRand = 1'b0;
    int xferIdx = 0;
    int waitCnt = 0;
    bit seenValid = 1'b0;
    bit prevStall = 1'b0;
    bit prevXfer = 1'b0;
    bit prevLast = 1'b0;
    int prevData = 0;
    int tcCount = 0;
    int armsAccepted = 0;

    task automatic check(input string name, input int act, input int req);
        nCmp++;
        if (act != req) begin
            nErr++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Consumer ready: always 1, or a fair coin when readyRand is set.
    initial begin
        rdIf.rdReady = 1'b1;
        forever begin
            @(posedge clk_PLL);
            #1;
            rdIf.rdReady = readyRand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Readout checker against the expected capture computed by run_capture.
    always @(negedge clk_PLL) begin
        if (trigClear) tcCount++;
        if (reset && expActive) begin
            if (prevStall) begin
                check("stallValid", int'(rdIf.rdValid), 1);
                check("stallData", int'(rdIf.rdData), prevData);
                check("stallLast", int'(rdIf.rdLast), int'(prevLast));
            end
            if (prevXfer && !prevLast) check("backToBack", int'(rdIf.rdValid), 1);
            if (done && !rdIf.rdValid && xferIdx == 0 && !seenValid) waitCnt++;
            if (rdIf.rdValid && !seenValid) begin
                seenValid = 1'b1;
                check("firstValidLatencyOk", int'(waitCnt <= 2), 1);
            end
            if (rdIf.rdValid && rdIf.rdReady) begin
                if (xferIdx < DEPTH) begin
                    check("rdData", int'(rdIf.rdData), expCap[xferIdx]);
                    check("rdLast", int'(rdIf.rdLast), int'(xferIdx == DEPTH - 1));
                    rxBuf[xferIdx] = int'(rdIf.rdData);
                end else begin
                    check("xferCount", xferIdx + 1, DEPTH);
                end
                xferIdx++;
            end
            prevStall = rdIf.rdValid && !rdIf.rdReady;
            prevXfer  = rdIf.rdValid && rdIf.rdReady;
            prevData  = int'(rdIf.rdData);
            prevLast  = rdIf.rdLast;
        end else begin
            if (reset && rdIf.rdValid) check("spuriousValid", int'(rdIf.rdValid), 0);
            prevStall = 1'b0;
            prevXfer  = 1'b0;
        end
    end

    task automatic reset_pulse();
        expActive = 1'b0;
        readyRand = 1'b0;
        reset     = 1'b0;
        arm       = 1'b0;
        triggerIn = 1'b0;
        @(posedge clk_PLL);
        #1;
        check("rstBusy", int'(busy), 0);
        check("rstDone", int'(done), 0);
        check("rstTrigClear", int'(trigClear), 0);
        check("rstValid", int'(rdIf.rdValid), 0);
        check("rstLast", int'(rdIf.rdLast), 0);
        check("rstData", int'(rdIf.rdData), 0);
        reset = 1'b1;
    endtask

    // One capture. Write k is the dataIn value in the k-th cycle after the arm
    // edge; the trigger write is the first k >= pre with triggerIn high, and the
    // capture is the DEPTH writes starting pre before it.
    task automatic run_capture(input int pre, input int trigAt, input int dataMode,
                               input bit rr, input bit randArm,
                               input int abortWrite, input int abortXfer);
        int t;
        int n;
        int guard;
        t = (trigAt > pre) ? trigAt : pre;
        n = t + DEPTH - pre + 2;
        for (int k = 0; k < n; k++) d[k] = (dataMode == 0) ? (k % 8) : int'($urandom_range(0, 7));
        for (int i = 0; i < DEPTH; i++) begin
            expCap[i] = d[t - pre + i];
            rxBuf[i]  = -1;
        end
        preTrigDepth = AW'(pre);
        arm = 1'b1;
        @(posedge clk_PLL);
        #1;
        armsAccepted++;
        xferIdx = 0; waitCnt = 0; seenValid = 1'b0;
        prevStall = 1'b0; prevXfer = 1'b0;
        readyRand = rr;
        expActive = 1'b1;
        check("trigClearPulse", int'(trigClear), 1);
        check("busyAfterArm", int'(busy), 1);
        check("doneClearedByArm", int'(done), 0);
        for (int k = 0; k < n; k++) begin
            if (k == abortWrite) begin
                reset_pulse();
                return;
            end
            dataIn    = DW'(d[k]);
            triggerIn = (k >= trigAt);
            arm       = randArm ? ($urandom_range(0, 3) == 0) : 1'b0;
            @(posedge clk_PLL);
            #1;
            if (k == 0) check("trigClearOneCycle", int'(trigClear), 0);
        end
        arm = 1'b0;
        triggerIn = 1'b0;
        guard = 0;
        while (xferIdx < DEPTH && guard < 300) begin
            if (abortXfer >= 0 && xferIdx >= abortXfer) begin
                reset_pulse();
                return;
            end
            @(posedge clk_PLL);
            #1;
            guard++;
        end
        check("readoutCount", xferIdx, DEPTH);
        check("endBusy", int'(busy), 0);
        check("endValid", int'(rdIf.rdValid), 0);
        check("doneHeld", int'(done), 1);
        expActive = 1'b0;
        readyRand = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        repeat (2) @(posedge clk_PLL);
        reset_pulse();
        @(posedge clk_PLL);
        #1;

        // pre=4, trigger 10 cycles into ARMED, counting data
        run_capture(4, 14, 0, 1'b0, 1'b0, -1, -1);
        check("t1ModelIdx4", expCap[4], 6);
        check("t1Rx0", rxBuf[0], 2);
        check("t1Rx4", rxBuf[4], 6);
        check("t1Rx15", rxBuf[15], 1);
        for (int i = 0; i < DEPTH; i++) refRx[i] = rxBuf[i];

        // Same capture with a random consumer and arm pokes while busy
        run_capture(4, 14, 0, 1'b1, 1'b1, -1, -1);
        for (int i = 0; i < DEPTH; i++) check("stallRunSame", rxBuf[i], refRx[i]);

        // pre=0, trigger on the first ARMED cycle
        run_capture(0, 0, 0, 1'b0, 1'b0, -1, -1);
        check("t2Rx0", rxBuf[0], 0);
        check("t2Rx15", rxBuf[15], 7);

        // pre=DEPTH-1: trigger sample is the last one read
        run_capture(15, 15, 0, 1'b0, 1'b0, -1, -1);
        check("t3Rx0", rxBuf[0], 0);
        check("t3Rx15", rxBuf[15], 7);

        // trigger held high throughout FILL
        run_capture(6, 0, 0, 1'b0, 1'b0, -1, -1);
        check("t4Rx5", rxBuf[5], 5);
        check("t4Rx6", rxBuf[6], 6);

        // reset mid-POST, then a clean capture
        run_capture(4, 5, 1, 1'b0, 1'b1, 8, -1);
        run_capture(4, 5, 1, 1'b1, 1'b0, -1, -1);
        // reset mid-READOUT, then a clean capture
        run_capture(7, 9, 1, 1'b1, 1'b0, -1, 5);
        run_capture(3, 10, 1, 1'b1, 1'b1, -1, -1);

        for (int r = 0; r < 6; r++) begin
            int p;
            p = int'($urandom_range(0, 15));
            run_capture(p, int'($urandom_range(0, p + 8)), 1, 1'b1, 1'b1, -1, -1);
        end

        check("trigClearCount", tcCount, armsAccepted);
        $display("== %0d vectors applied, %0d miscompares ==", nCmp, nErr);
        $finish;
    end
endmodule

// File: doc/capture_buffer.md
Name: capture_buffer

Overview:
- Sample buffer directly downstream of the trigger stage.
- Consumes the trigger stage's registered 3-bit sample stream and its sticky trigger flag.
- Keeps a circular pre-trigger history and captures a fixed post-trigger window.
- Streams the full capture, oldest sample first, to the host-readout stage over a valid/ready handshake. Also generates the trigger-stage clear pulse when arming.

Parameters:
- DATA_WIDTH, 3, sample width; matches the trigger stage data output.
- ADDR_WIDTH, 8, buffer address width; DEPTH = 2**ADDR_WIDTH samples per capture.

Ports:
- clk_PLL  input  1  sampling clock, same clock as the trigger stage.
- reset  input  1  synchronous, active-low reset.
- arm  input  1  start-capture request; honoured only in IDLE.
- dataIn  input  DATA_WIDTH  sample from the trigger stage data output.
- triggerIn  input  1  sticky trigger flag from the trigger stage.
- preTrigDepth  input  ADDR_WIDTH  number of pre-trigger samples to keep; sampled at arm.
- trigClear  output  1  one-cycle active-high pulse driving the trigger stage reset.
- busy  output  1  high in FILL, ARMED, POST and READOUT.
- done  output  1  high from entry to READOUT until the next accepted arm or reset.
- rdValid  output  1  rdData is valid.
- rdReady  input  1  consumer accepts rdData.
- rdData  output  DATA_WIDTH  readout sample.
- rdLast  output  1  high together with rdValid on the DEPTH-th (final) sample.

Behaviour:
- Reset (reset==0 at a clk_PLL edge):
  - State goes to IDLE.
  - trigClear, busy, done, rdValid, rdLast, rdData and all pointers/counters go to 0.
  - Memory contents are don't-care.
  - Reset overrides every other input and aborts any state, including mid-readout.
- States: IDLE, FILL, ARMED, POST, READOUT.
- IDLE: on arm=1:
  - latch pre = min(preTrigDepth, DEPTH-1) and clear the write pointer and counters;
  - assert trigClear for exactly 1 cycle;
  - go to FILL, or to ARMED if pre==0.
  - arm in any other state is ignored.
- Writes: in FILL, ARMED and POST, every cycle writes dataIn at wrPtr, then wrPtr increments mod DEPTH.
- FILL:
  - counts writes; after pre writes, go to ARMED.
  - triggerIn is ignored in FILL, so the pre-trigger history is always complete.
- ARMED:
  - circular writing continues.
  - The first cycle with triggerIn==1 marks the trigger sample: that cycle's write is post-sample #1.
  - startAddr := (wrPtr - pre) mod DEPTH.
  - Next state is POST, or READOUT if DEPTH - pre == 1.
- POST: writes until DEPTH - pre post-trigger samples in total (counting the trigger sample) have been written, then READOUT. No further writes after that.
- Total capture is always exactly DEPTH samples. Sample at index pre, counting from startAddr, is the trigger sample.
- triggerIn is sticky upstream. Only its level during ARMED matters, and trigClear guarantees it is low for at least the first ARMED cycle after a fresh arm.
- READOUT:
  - reads DEPTH samples from startAddr upward, wrapping mod DEPTH.
  - Memory read latency is 1 cycle; the implementation prefetches. First rdValid is asserted no later than 2 cycles after entering READOUT.
- Handshake:
  - A transfer occurs on a cycle with rdValid && rdReady.
  - While rdValid && !rdReady, rdData and rdLast hold stable and rdValid stays high.
  - Back-to-back transfers at 1 sample per cycle must be sustained while rdReady is held high.
- On the transfer with rdLast=1: go to IDLE with rdValid=0 next cycle; done stays 1 until the next accepted arm.
- Counter widths: post and read counters are ADDR_WIDTH+1 bits so that the value DEPTH is representable. Address arithmetic wraps mod DEPTH.

Test Plan:
- ADDR_WIDTH=4, pre=4, dataIn = cycle count mod 8, trigger 10 cycles after ARMED -> 16 samples read. Sample index 4 equals the dataIn value on the trigger cycle. Indices 0..3 are the 4 preceding values. rdLast only on the 16th sample.
- pre=0, trigger on the first ARMED cycle -> no FILL state. Trigger sample is rdData index 0. 16 contiguous post samples.
- preTrigDepth=15 (DEPTH-1): trigger sample is the last read (index 15, with rdLast=1); POST is skipped, straight to READOUT.
- triggerIn held 1 during FILL (pre=6) -> ignored. Capture triggers on the first ARMED cycle. Exactly 6 pre samples precede the trigger sample.
- Random rdReady (50%) during readout -> rdData stable during stalls. Sequence is identical to the rdReady=1 run. Exactly 16 transfers.
- reset=0 asserted mid-POST and again mid-READOUT -> next cycle all outputs are 0 and state is IDLE. A following arm produces a correct full capture. trigClear pulses exactly once per accepted arm; arm while busy has no effect.
